// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port unified word memory between the
// instruction-fetch port and the data load/store port. Each cycle it picks
// one requester, checks the access (alignment, range, region), drives the
// memory macro, and returns exactly one response per grant one cycle later
// with load data aligned and extended.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_BYTES    = 65536,
    parameter int IMEM_BYTES   = 16384,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // instruction fetch port
    input  logic                         if_req,
    input  logic [ADDR_WIDTH-1:0]        if_addr,
    output logic                         if_gnt,
    output logic                         if_rsp_valid,
    output logic [DATA_WIDTH-1:0]        if_rdata,
    output logic [1:0]                   if_err,
    // data load/store port
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [ADDR_WIDTH-1:0]        d_addr,
    input  logic [1:0]                   d_n_bytes,
    input  logic                         d_unsigned,
    input  logic [DATA_WIDTH-1:0]        d_wdata,
    output logic                         d_gnt,
    output logic                         d_rsp_valid,
    output logic [DATA_WIDTH-1:0]        d_rdata,
    output logic [1:0]                   d_err,
    // memory macro
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [3:0]                   mem_be,
    output logic [$clog2(MEM_BYTES)-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);

    localparam int WADDR_WIDTH = $clog2(MEM_BYTES) - 2;
    localparam int CNT_WIDTH   = $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_WIDTH-1:0] MEM_END    = ADDR_WIDTH'(MEM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] IMEM_END   = ADDR_WIDTH'(IMEM_BYTES);
    localparam logic [CNT_WIDTH-1:0]  STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

    // error codes shared by both response ports
    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_ALIGN  = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;
    localparam logic [1:0] ERR_REGION = 2'b11;

    // normalised access size (d_n_bytes 1x collapses to word)
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
    logic                  grant_if, grant_d, any_grant;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_size;
    logic                  sel_we;
    logic                  sel_unsigned;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  misaligned, out_of_range, region_bad;
    logic [1:0]            access_err;
    logic                  access_ok;

    logic [3:0]            be_byte, be_half;
    logic [DATA_WIDTH-1:0] wdata_byte_rep, wdata_half_rep;

    logic                  rsp_valid_q,    rsp_valid_d;
    logic                  rsp_fetch_q,    rsp_fetch_d;
    logic [1:0]            rsp_lsb_q,      rsp_lsb_d;
    logic [1:0]            rsp_size_q,     rsp_size_d;
    logic                  rsp_unsigned_q, rsp_unsigned_d;
    logic                  rsp_we_q,       rsp_we_d;
    logic [1:0]            rsp_err_q,      rsp_err_d;

    logic [7:0]            rd_lane [4];
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic [DATA_WIDTH-1:0] load_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Data has priority unless fetch has been starved for the full limit;
    // nothing is granted while reset is asserted so all outputs stay quiet.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                if (starve_cnt_q == STARVE_MAX) begin
                    grant_if = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    assign any_grant = grant_if | grant_d;
    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;

    // Count consecutive cycles a pending fetch lost; saturate at the limit.
    always_comb begin
        starve_cnt_d = '0;
        if (if_req && !grant_if) begin
            if (starve_cnt_q == STARVE_MAX) begin
                starve_cnt_d = STARVE_MAX;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Winner attribute mux and access checks
    // ------------------------------------------------------------------

    // Route the winner's attributes; a fetch is always a word read.
    always_comb begin
        sel_addr     = '0;
        sel_size     = SIZE_WORD;
        sel_we       = 1'b0;
        sel_unsigned = 1'b0;
        sel_wdata    = '0;
        if (grant_if) begin
            sel_addr = if_addr;
        end else if (grant_d) begin
            sel_addr     = d_addr;
            sel_size     = d_n_bytes[1] ? SIZE_WORD : d_n_bytes;
            sel_we       = d_we;
            sel_unsigned = d_unsigned;
            sel_wdata    = d_wdata;
        end
    end

    // Classify the selected access; alignment beats range beats region.
    always_comb begin
        misaligned   = ((sel_size == SIZE_HALF) && sel_addr[0]) ||
                       ((sel_size == SIZE_WORD) && (sel_addr[1:0] != 2'b00));
        out_of_range = (sel_addr >= MEM_END);
        // fetch must stay in the instruction region; stores may not touch it
        region_bad   = grant_if ? (sel_addr >= IMEM_END)
                                : (sel_we && (sel_addr < IMEM_END));
        if (misaligned) begin
            access_err = ERR_ALIGN;
        end else if (out_of_range) begin
            access_err = ERR_RANGE;
        end else if (region_bad) begin
            access_err = ERR_REGION;
        end else begin
            access_err = ERR_OK;
        end
    end

    assign access_ok = any_grant && (access_err == ERR_OK);

    // ------------------------------------------------------------------
    // Memory drive
    // ------------------------------------------------------------------

    assign be_byte = 4'b0001 << sel_addr[1:0];
    assign be_half = 4'b0011 << {sel_addr[1], 1'b0};

    // Store data replicated on every lane so the byte enables pick the slot.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wdata_byte_rep[gi*8 +: 8] = sel_wdata[7:0];
        assign wdata_half_rep[gi*8 +: 8] = sel_wdata[(gi % 2)*8 +: 8];
    end

    // Drive the macro only for a clean grant; otherwise hold everything at 0.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (access_ok) begin
            mem_en   = 1'b1;
            mem_we   = sel_we;
            mem_addr = sel_addr[WADDR_WIDTH+1:2];
            case (sel_size)
                SIZE_BYTE: mem_be = be_byte;
                SIZE_HALF: mem_be = be_half;
                default:   mem_be = 4'b1111;
            endcase
            if (sel_we) begin
                case (sel_size)
                    SIZE_BYTE: mem_wdata = wdata_byte_rep;
                    SIZE_HALF: mem_wdata = wdata_half_rep;
                    default:   mem_wdata = sel_wdata;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------

    // Capture what the response stage needs to know about this grant.
    always_comb begin
        rsp_valid_d    = any_grant;
        rsp_fetch_d    = grant_if;
        rsp_lsb_d      = sel_addr[1:0];
        rsp_size_d     = sel_size;
        rsp_unsigned_d = sel_unsigned;
        rsp_we_d       = sel_we;
        rsp_err_d      = access_err;
    end

    // Response register; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q    <= 1'b0;
            rsp_fetch_q    <= 1'b0;
            rsp_lsb_q      <= 2'b00;
            rsp_size_q     <= SIZE_BYTE;
            rsp_unsigned_q <= 1'b0;
            rsp_we_q       <= 1'b0;
            rsp_err_q      <= ERR_OK;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_fetch_q    <= rsp_fetch_d;
            rsp_lsb_q      <= rsp_lsb_d;
            rsp_size_q     <= rsp_size_d;
            rsp_unsigned_q <= rsp_unsigned_d;
            rsp_we_q       <= rsp_we_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    // Split the returned word into byte lanes for load alignment.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rlane
        assign rd_lane[gi] = mem_rdata[gi*8 +: 8];
    end

    // Align the addressed byte/halfword to bit 0 and extend it.
    always_comb begin
        byte_val = rd_lane[rsp_lsb_q];
        half_val = rsp_lsb_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (rsp_size_q)
            SIZE_BYTE: load_data = {{24{~rsp_unsigned_q & byte_val[7]}}, byte_val};
            SIZE_HALF: load_data = {{16{~rsp_unsigned_q & half_val[15]}}, half_val};
            default:   load_data = mem_rdata;
        endcase
    end

    // Steer the registered response to its owner; stores and errors carry no data.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rdata     = '0;
        if_err       = ERR_OK;
        d_rsp_valid  = 1'b0;
        d_rdata      = '0;
        d_err        = ERR_OK;
        if (rsp_valid_q) begin
            if (rsp_fetch_q) begin
                if_rsp_valid = 1'b1;
                if_err       = rsp_err_q;
                if (rsp_err_q == ERR_OK) begin
                    if_rdata = mem_rdata;
                end
            end else begin
                d_rsp_valid = 1'b1;
                d_err       = rsp_err_q;
                if ((rsp_err_q == ERR_OK) && !rsp_we_q) begin
                    d_rdata = load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a per-cycle
// comparison against a behavioural model, plus literal expectations.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rsp_valid;
    logic [31:0] if_rdata;
    logic [1:0]  if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_n_bytes;
    logic        d_unsigned;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic [1:0]  d_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_n_bytes(d_n_bytes),
        .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend;
    bit          m_pend_fetch;
    bit          m_pend_we;
    bit          m_pend_uns;
    int unsigned m_pend_addr;
    int          m_pend_nb;
    int          m_pend_err;
    int          m_starve;

    function automatic int nbytes_of(input logic [1:0] n);
        if (n == 2'b00) return 1;
        if (n == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int model_err(input bit fetch, input bit we, input int unsigned a, input int nb);
        if ((a % nb) != 0) return 1;
        if (a >= 65536) return 2;
        if (fetch && a >= 16384) return 3;
        if (!fetch && we && a < 16384) return 3;
        return 0;
    endfunction

    function automatic int unsigned model_be(input int unsigned a, input int nb);
        if (nb == 1) return 1 << (a % 4);
        if (nb == 2) return 3 << (a % 4);
        return 15;
    endfunction

    function automatic int unsigned model_wdata(input int unsigned w, input int nb);
        if (nb == 1) return (w % 256) * 32'h0101_0101;
        if (nb == 2) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic int unsigned model_load(input int unsigned rd, input int unsigned a, input int nb, input bit uns);
        int unsigned v;
        int unsigned span;
        if (nb == 4) return rd;
        span = 32'd1 << (8 * nb);
        v = (rd >> (8 * (a % 4))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return v;
    endfunction

    // One compare per negedge: expected outputs from the current inputs plus
    // the model's remembered grant from the previous cycle.
    task automatic check_cycle();
        int          who;
        bit          fetch;
        int unsigned a;
        int          nb;
        bit          we;
        int          err;
        bit          ok;
        int unsigned e_if_rdata;
        int unsigned e_d_rdata;
        if (rst) begin
            chk("rst_ctrl", 32'({if_gnt, if_rsp_valid, if_err, d_gnt, d_rsp_valid, d_err,
                                 mem_en, mem_we, mem_be, mem_addr}), 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            m_pend   = 1'b0;
            m_starve = 0;
            return;
        end
        who = 0;
        if (if_req && d_req) who = (m_starve == 4) ? 1 : 2;
        else if (if_req)     who = 1;
        else if (d_req)      who = 2;
        fetch = (who == 1);
        a     = fetch ? if_addr : d_addr;
        nb    = fetch ? 4 : nbytes_of(d_n_bytes);
        we    = fetch ? 1'b0 : d_we;
        err   = model_err(fetch, we, a, nb);
        ok    = (who != 0) && (err == 0);

        chk("if_gnt", 32'(if_gnt), 32'(who == 1));
        chk("d_gnt", 32'(d_gnt), 32'(who == 2));
        chk("mem_en", 32'(mem_en), 32'(ok));
        chk("mem_we", 32'(mem_we), 32'(ok && we));
        chk("mem_be", 32'(mem_be), ok ? model_be(a, nb) : 32'd0);
        chk("mem_addr", 32'(mem_addr), ok ? (a / 4) % 16384 : 32'd0);
        chk("mem_wdata", mem_wdata, (ok && we) ? model_wdata(d_wdata, nb) : 32'd0);

        e_if_rdata = (m_pend && m_pend_fetch && m_pend_err == 0) ? mem_rdata : 32'd0;
        e_d_rdata  = (m_pend && !m_pend_fetch && !m_pend_we && m_pend_err == 0)
                     ? model_load(mem_rdata, m_pend_addr, m_pend_nb, m_pend_uns) : 32'd0;
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(m_pend && m_pend_fetch));
        chk("if_err", 32'(if_err), (m_pend && m_pend_fetch) ? 32'(m_pend_err) : 32'd0);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rsp_valid", 32'(d_rsp_valid), 32'(m_pend && !m_pend_fetch));
        chk("d_err", 32'(d_err), (m_pend && !m_pend_fetch) ? 32'(m_pend_err) : 32'd0);
        chk("d_rdata", d_rdata, e_d_rdata);

        m_pend       = (who != 0);
        m_pend_fetch = fetch;
        m_pend_we    = we;
        m_pend_uns   = d_unsigned;
        m_pend_addr  = a;
        m_pend_nb    = nb;
        m_pend_err   = err;
        if (if_req && who != 1) m_starve = (m_starve >= 4) ? 4 : m_starve + 1;
        else                    m_starve = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_cycle();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req     = 1'b0;
        if_addr    = 32'd0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = 32'd0;
        d_n_bytes  = 2'b00;
        d_unsigned = 1'b0;
        d_wdata    = 32'd0;
    endtask

    task automatic set_d(input logic we, input logic [31:0] addr, input logic [1:0] nb,
                         input logic uns, input logic [31:0] wdata);
        d_req      = 1'b1;
        d_we       = we;
        d_addr     = addr;
        d_n_bytes  = nb;
        d_unsigned = uns;
        d_wdata    = wdata;
    endtask

    task automatic set_if(input logic [31:0] addr);
        if_req  = 1'b1;
        if_addr = addr;
    endtask

    // advance to the response cycle of the previous grant with a given read word
    task automatic resp_cycle(input logic [31:0] rd);
        step();
        idle();
        mem_rdata = rd;
        #2;
    endtask

    logic [1:0] seq [10];

    initial begin
        rst       = 1'b1;
        mem_rdata = 32'd0;
        idle();
        seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        repeat (3) @(posedge clk);
        #3;
        chk("lit_reset_quiet", 32'({if_gnt, d_gnt, mem_en, if_rsp_valid, d_rsp_valid}), 32'd0);
        step();
        rst = 1'b0;
        #2;
        chk("lit_idle_quiet", 32'({if_gnt, d_gnt, mem_en, if_rsp_valid, d_rsp_valid}), 32'd0);

        // load word 0x4008
        step();
        set_d(1'b0, 32'h0000_4008, 2'b10, 1'b0, 32'd0);
        #2;
        chk("lit_lw_gnt", 32'(d_gnt), 32'd1);
        chk("lit_lw_addr", 32'(mem_addr), 32'h1002);
        chk("lit_lw_be", 32'(mem_be), 32'hF);
        resp_cycle(32'hDEAD_BEEF);
        chk("lit_lw_valid", 32'(d_rsp_valid), 32'd1);
        chk("lit_lw_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("lit_lw_err", 32'(d_err), 32'd0);
        $display("[TB] load word 0x4008 -> rdata %08h err %0d", d_rdata, d_err);

        // load byte 0x4003 signed / unsigned
        step();
        set_d(1'b0, 32'h0000_4003, 2'b00, 1'b0, 32'd0);
        #2;
        chk("lit_lb_be", 32'(mem_be), 32'h8);
        resp_cycle(32'h80FF_0000);
        chk("lit_lb_rdata", d_rdata, 32'hFFFF_FF80);
        $display("[TB] load byte signed 0x4003 -> rdata %08h", d_rdata);
        step();
        set_d(1'b0, 32'h0000_4003, 2'b00, 1'b1, 32'd0);
        #2;
        resp_cycle(32'h80FF_0000);
        chk("lit_lbu_rdata", d_rdata, 32'h0000_0080);
        $display("[TB] load byte unsigned 0x4003 -> rdata %08h", d_rdata);

        // store half 0x1234 to 0x4006
        step();
        set_d(1'b1, 32'h0000_4006, 2'b01, 1'b0, 32'h0000_1234);
        #2;
        chk("lit_sh_we", 32'(mem_we), 32'd1);
        chk("lit_sh_be", 32'(mem_be), 32'hC);
        chk("lit_sh_wdata", mem_wdata, 32'h1234_1234);
        resp_cycle(32'h7777_7777);
        chk("lit_sh_valid", 32'(d_rsp_valid), 32'd1);
        chk("lit_sh_err", 32'(d_err), 32'd0);
        chk("lit_sh_rdata", d_rdata, 32'd0);
        $display("[TB] store half 0x4006 -> err %0d", d_err);

        // error cases
        step();
        set_d(1'b0, 32'h0000_4002, 2'b10, 1'b0, 32'd0);
        #2;
        chk("lit_mis_en", 32'(mem_en), 32'd0);
        resp_cycle(32'h1111_1111);
        chk("lit_mis_err", 32'(d_err), 32'd1);
        chk("lit_mis_rdata", d_rdata, 32'd0);
        $display("[TB] load word 0x4002 -> err %0d", d_err);

        step();
        set_d(1'b0, 32'h0001_0000, 2'b10, 1'b0, 32'd0);
        #2;
        resp_cycle(32'h2222_2222);
        chk("lit_range_err", 32'(d_err), 32'd2);
        $display("[TB] load word 0x10000 -> err %0d", d_err);

        step();
        set_d(1'b1, 32'h0000_0100, 2'b00, 1'b0, 32'h0000_00AB);
        #2;
        chk("lit_sreg_en", 32'(mem_en), 32'd0);
        resp_cycle(32'h3333_3333);
        chk("lit_sreg_err", 32'(d_err), 32'd3);
        $display("[TB] store byte 0x0100 -> err %0d", d_err);

        step();
        set_if(32'h0000_4000);
        #2;
        chk("lit_freg_gnt", 32'(if_gnt), 32'd1);
        resp_cycle(32'h4444_4444);
        chk("lit_freg_err", 32'(if_err), 32'd3);
        chk("lit_freg_rdata", if_rdata, 32'd0);
        $display("[TB] fetch 0x4000 -> err %0d", if_err);

        // both requesters held high: starvation forces every fifth grant to fetch
        step();
        set_if(32'h0000_0010);
        set_d(1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'd0);
        for (int k = 0; k < 10; k++) begin
            mem_rdata = 32'h1000_0000 + 32'(k);
            #2;
            chk("lit_arb_seq", 32'({if_gnt, d_gnt}), 32'(seq[k]));
            if (k > 0) chk("lit_arb_rsp", 32'({if_rsp_valid, d_rsp_valid}), 32'(seq[k-1]));
            $display("[TB] contention cycle %0d -> grant %s", k, if_gnt ? "I" : "D");
            step();
        end
        idle();
        #2;
        chk("lit_arb_last_rsp", 32'(if_rsp_valid), 32'd1);

        // reset in the cycle after a load grant discards the response
        step();
        set_d(1'b0, 32'h0000_4004, 2'b10, 1'b0, 32'd0);
        #2;
        chk("lit_rl_gnt", 32'(d_gnt), 32'd1);
        step();
        idle();
        rst       = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        #2;
        chk("lit_rl_no_rsp", 32'({d_rsp_valid, if_rsp_valid}), 32'd0);
        chk("lit_rl_rdata", d_rdata, 32'd0);
        step();
        step();
        rst = 1'b0;
        #2;
        chk("lit_rl_release", 32'({d_rsp_valid, if_rsp_valid, mem_en}), 32'd0);
        step();
        set_if(32'h0000_0000);
        #2;
        chk("lit_rf_gnt", 32'(if_gnt), 32'd1);
        chk("lit_rf_addr", 32'(mem_addr), 32'd0);
        resp_cycle(32'hCAFE_F00D);
        chk("lit_rf_valid", 32'(if_rsp_valid), 32'd1);
        chk("lit_rf_rdata", if_rdata, 32'hCAFE_F00D);
        chk("lit_rf_err", 32'(if_err), 32'd0);
        $display("[TB] fetch 0x0000 after reset -> rdata %08h", if_rdata);
        step();
        #2;
        chk("lit_rf_single", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified memory (64 KiB, 32-bit words, byte addressed) between the instruction-fetch port and the data load/store port.
- Arbitrates between the two ports, checks each access for alignment, range and region, and generates byte enables for stores.
- Aligns, sign-extends or zero-extends load data and returns one response per grant, one cycle after the grant.
- Sits between the core's IF/MEM stages and the memory macro.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requester ports.
- DATA_WIDTH, 32, word width; fixed at 32.
- MEM_BYTES, 65536, total memory size; accesses at or above this are out of range.
- IMEM_BYTES, 16384, instruction region [0, IMEM_BYTES); data region [IMEM_BYTES, MEM_BYTES).
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; attributes held stable until granted
- if_addr  in  32  fetch byte address; always a word access
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rsp_valid  out  1  fetch response valid
- if_rdata  out  32  fetched word
- if_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 region violation
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_n_bytes  in  2  00 byte, 01 halfword, 1x word
- d_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores and words
- d_wdata  in  32  store data, right-justified
- d_gnt  out  1  data granted this cycle
- d_rsp_valid  out  1  data response valid (loads and stores)
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_err  out  2  same encoding as if_err
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write
- mem_be  out  4  byte enables (bit i = byte lane i)
- mem_addr  out  14  word address = byte address[15:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data; valid the cycle after mem_en

Behaviour:
- Reset: all outputs 0, response pipeline register cleared, starvation counter 0. Reset asserted mid-access discards the pending response; no rsp_valid after reset release.

Arbitration, combinational each cycle:
- Only one requester pending: it wins.
- Both pending: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Winner's gnt = 1; at most one gnt per cycle; back-to-back grants every cycle are allowed.

Starvation counter:
- Increments when if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
- Clears on if_gnt or when if_req=0.

Error checks on the granted request, in priority order:
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Out of range: addr >= MEM_BYTES.
- Region violation:
  - fetch with addr >= IMEM_BYTES;
  - store with addr < IMEM_BYTES;
  - loads may read either region.
- An erroring grant drives mem_en=0 but still produces a response.

Memory drive for a granted, error-free access (same cycle as grant):
- mem_en=1; mem_we=d_we for data, 0 for fetch.
- mem_be:
  - byte: 0001<<addr[1:0];
  - half: 0011<<{addr[1],0};
  - word or fetch: 1111.
- mem_wdata:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- With no grant: mem_en=0, other memory outputs 0.

Response pipeline:
- Registered at grant: owner, addr[1:0], size, unsigned, we, err.
- At T+1: the owner's rsp_valid=1 for exactly one cycle; err as registered.

Load data at T+1:
- Byte: lane addr[1:0] of mem_rdata, sign- or zero-extended.
- Half: lane pair addr[1], sign- or zero-extended.
- Word: mem_rdata unchanged.

Other response rules:
- Stores and errors return rdata=0.
- A grant at T and a response for the T-1 grant may coexist in the same cycle.

Test Plan:
- Reset, then both idle: all outputs 0 -> d_req load word 0x4008; mem_addr=0x1002, mem_be=1111; next cycle d_rsp_valid=1, d_rdata=mem_rdata, d_err=00.
- Load byte at 0x4003 signed, mem_rdata=0x80FF_0000 -> mem_be=1000 at grant, d_rdata=0xFFFF_FF80; same with d_unsigned=1 -> 0x0000_0080.
- Store half 0x1234 to 0x4006 -> mem_we=1, mem_be=1100, mem_wdata=0x1234_1234, next cycle d_rsp_valid=1, d_err=00.
- Errors:
  - load word at 0x4002 -> d_err=01, mem_en=0;
  - load at 0x0001_0000 -> d_err=10;
  - store byte at 0x0100 -> d_err=11;
  - fetch at 0x4000 -> if_err=11.
- if_req and d_req held high continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; responses one cycle after each grant to the correct port.
- Assert rst in the cycle after a load grant -> no d_rsp_valid, all outputs 0; after release a fresh fetch at 0x0000 returns if_rsp_valid next cycle.
